// File: rtl/counter_pkg.sv
// Shared types and defaults for the multimode counter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: count_mode_t encodes the 2-bit mode pin; DEFAULT_* are the
// parameter defaults used by the counter and its prescaler.
package counter_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PRESCALE_W = 4;

  // mode[1] selects saturate behaviour, mode[0] selects counting down.
  typedef enum logic [1:0] {
    CM_UP_WRAP   = 2'b00,
    CM_DOWN_WRAP = 2'b01,
    CM_UP_SAT    = 2'b10,
    CM_DOWN_SAT  = 2'b11
  } count_mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: emits one tick every prescale+1 enabled cycles.
// Latency: tick is combinational from the divider state and en.
// Backpressure: none; en low freezes the divider, clr restarts it.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            advance the divider this cycle
//   clr           synchronous restart of the divider (wins over en)
//   prescale      divide ratio minus one
//   tick          high in the cycle the counter should step
module tick_prescaler #(
  parameter int PRESCALE_W = counter_pkg::DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pdiv_q, pdiv_d;

  // Equality (not >=) is deliberate: lowering prescale below the current
  // divider value lets it roll through the full range before the next tick.
  assign tick = en && (pdiv_q == prescale);

  always_comb begin
    pdiv_d = pdiv_q;
    if (clr || tick) begin
      pdiv_d = '0;
    end else if (en) begin
      pdiv_d = pdiv_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdiv_q <= '0;
    end else begin
      pdiv_q <= pdiv_d;
    end
  end

endmodule

// File: rtl/multimode_counter.sv
// Up/down, wrap/saturate counter with modulo limit, load and prescaled enable.
// Latency: count and tc update on the edge ending a tick or load cycle.
// Backpressure: none; en gates stepping, load overrides everything.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            count enable (feeds the prescaler)
//   mode          count_mode_t encoding of direction and wrap/saturate
//   load,load_val synchronous load of the count, restarts the prescaler
//   limit         top of the count range 0..limit
//   prescale      count steps once every prescale+1 enabled cycles
//   count         registered count
//   tc            registered one-cycle terminal-count pulse
//   sat           saturate mode sitting on its boundary
module multimode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  sat
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic [WIDTH-1:0] inc, dec, boundary;
  count_mode_t      mode_e;

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  assign mode_e   = count_mode_t'(mode);
  assign inc      = count_q + ONE;
  assign dec      = count_q - ONE;
  assign boundary = mode[0] ? '0 : limit;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (tick) begin
      case (mode_e)
        CM_UP_WRAP: begin
          // >= also catches a loaded value above limit.
          if (count_q >= limit) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = inc;
          end
        end
        CM_DOWN_WRAP: begin
          if (count_q == '0) begin
            count_d = limit;
            tc_d    = 1'b1;
          end else begin
            count_d = dec;
          end
        end
        CM_UP_SAT: begin
          // Holding at (or above) limit never re-pulses tc.
          if (count_q >= limit) begin
            count_d = limit;
          end else begin
            count_d = inc;
            tc_d    = (inc == limit);
          end
        end
        CM_DOWN_SAT: begin
          if (count_q != '0) begin
            count_d = dec;
            tc_d    = (dec == '0);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign sat   = mode[1] && (count_q == boundary);

endmodule
